// File: rtl/keyboard_event_fifo.sv
// keyboard_event_fifo: buffers key codes from the keyboard decoder and exposes
// them to the processor through a small Avalon-MM register slave.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address[1:0]            Avalon word address (0 DATA, 1 STATUS, 2 CONTROL, 3 reserved)
//   chipselect, read, write Avalon slave strobes (read/write qualified by chipselect)
//   writedata[31:0]         write data
//   readdata[31:0]          registered read data, latency 1, held when idle
//   key_code[DATA_WIDTH-1:0], key_valid   key code and one-cycle strobe from the decoder
//   irq                     registered level interrupt: irq_en & FIFO not empty
module keyboard_event_fifo #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] key_code,
    input  logic                  key_valid,
    output logic                  irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  irq_en;

    logic        bus_rd, bus_wr;
    logic        is_empty, is_full;
    logic        pop, push, flush;
    logic        ovf_set, ovf_clr;
    logic [31:0] rd_word;

    // Only bits 0, 1 and 18 of writedata carry meaning.
    logic unused_writedata;
    assign unused_writedata = ^{writedata[31:19], writedata[17:2]};

    // Transaction decode and FIFO event arbitration.
    always_comb begin
        bus_rd   = chipselect & read;
        bus_wr   = chipselect & write;
        is_empty = (count == '0);
        is_full  = (count == FULL_CNT);
        pop      = bus_rd && (address == ADDR_DATA) && !is_empty;
        flush    = bus_wr && (address == ADDR_CTRL) && writedata[1];
        // A same-cycle pop frees the slot, so a full FIFO can still accept.
        push     = key_valid && !flush && (!is_full || pop);
        ovf_set  = key_valid && !flush && is_full && !pop;
        ovf_clr  = bus_wr && (address == ADDR_STATUS) && writedata[18];
    end

    // Read mux, built from the state before this edge.
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: begin
                if (!is_empty) begin
                    rd_word[15]               = 1'b1;
                    rd_word[DATA_WIDTH-1:0]   = mem[rd_ptr];
                end
            end
            ADDR_STATUS: begin
                rd_word[8:0] = 9'(count);
                rd_word[16]  = is_empty;
                rd_word[17]  = is_full;
                rd_word[18]  = overflow;
            end
            ADDR_CTRL: begin
                rd_word[0] = irq_en;
            end
            default: begin
            end
        endcase
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_code;
        end
    end

    // Pointers, count and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end

            // Set has priority over a same-cycle clear.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (bus_wr && (address == ADDR_CTRL)) begin
                irq_en <= writedata[0];
            end

            irq <= irq_en & !is_empty;
        end
    end

    // Read data register, held when no read is active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (bus_rd) begin
            readdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_keyboard_event_fifo.sv
// Self-checking bench for keyboard_event_fifo (DEPTH 16, DATA_WIDTH 8).
module tb_keyboard_event_fifo;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  key_code;
    logic        key_valid;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } sb_t;

    typedef struct {
        bit          kv;
        logic [7:0]  kc;
        bit          rd;
        bit          wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[$];

    keyboard_event_fifo #(.DEPTH(16), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One bus/key cycle; reads queue their expectation and are scored when readdata lands.
    task automatic cyc(input bit kv, input logic [7:0] kc, input bit rd, input bit wr,
                       input logic [1:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string nm);
        sb_t e;
        @(negedge clk);
        key_valid  = kv;
        key_code   = kc;
        chipselect = rd | wr;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        if (rd) begin
            e.exp = exp;
            e.nm  = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        if (rd) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: scoreboard empty", nm);
            end else begin
                e = sb.pop_front();
                check(e.nm, readdata, e.exp);
            end
        end
    endtask

    task automatic key(input logic [7:0] c);
        cyc(1'b1, c, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0, exp, nm);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, a, wd, 32'h0, "");
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, "");
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        key_code   = 8'h00;
        key_valid  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic ordering, empty read, reserved address, ignored DATA write.
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0001_0000});
        tbl.push_back('{1'b1, 8'h1C, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 8'h32, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 8'h21, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0000_0003});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_801C});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_8032});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_8021});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_0000});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0001_0000});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0000_0000});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 32'h55, 32'h0});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0001_0000});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0000_0000});
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].kv, tbl[i].kc, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd,
                tbl[i].exp, $sformatf("vec%0d", i));
        end
        check("irq_disabled", 32'(irq), 32'h0);

        // Overflow on the 17th code, drain, then clear.
        for (int i = 0; i < 17; i++) key(8'(i));
        rd(2'd1, 32'h0006_0010, "ovf_status");
        for (int i = 0; i < 16; i++) rd(2'd0, 32'h8000 | 32'(i), $sformatf("ovf_drain%0d", i));
        rd(2'd1, 32'h0005_0000, "ovf_sticky");
        wr(2'd1, 32'h0004_0000);
        rd(2'd1, 32'h0001_0000, "ovf_cleared");

        // Full FIFO: push coincident with pop does not overflow.
        for (int i = 0; i < 16; i++) key(8'h60 + 8'(i));
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_8060, "full_pushpop");
        rd(2'd1, 32'h0002_0010, "full_pushpop_status");
        for (int i = 1; i < 16; i++) rd(2'd0, 32'h8060 | 32'(i), $sformatf("full_drain%0d", i));
        rd(2'd0, 32'h0000_8055, "full_last");

        // Push and pop on an empty FIFO.
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, "empty_pushpop");
        rd(2'd1, 32'h0000_0001, "empty_pushpop_status");
        rd(2'd0, 32'h0000_8077, "empty_pushpop_data");

        // Interrupt assert and flush-driven deassert.
        wr(2'd2, 32'h1);
        key(8'h1C);
        idle();
        check("irq_set", 32'(irq), 32'h1);
        wr(2'd2, 32'h3);
        idle();
        check("irq_flush", 32'(irq), 32'h0);
        rd(2'd1, 32'h0001_0000, "flush_status");
        rd(2'd2, 32'h0000_0001, "ctrl_read");

        // Flush beats a same-cycle push.
        key(8'h10);
        cyc(1'b1, 8'h44, 1'b0, 1'b1, 2'd2, 32'h3, 32'h0, "");
        rd(2'd1, 32'h0001_0000, "flush_push");

        // Overflow set beats a same-cycle clear; flush keeps overflow.
        for (int i = 0; i < 16; i++) key(8'(i));
        cyc(1'b1, 8'h99, 1'b0, 1'b1, 2'd1, 32'h0004_0000, 32'h0, "");
        rd(2'd1, 32'h0006_0010, "ovf_set_wins");
        wr(2'd2, 32'h3);
        rd(2'd1, 32'h0005_0000, "flush_keeps_ovf");
        wr(2'd1, 32'h0004_0000);
        rd(2'd1, 32'h0001_0000, "ovf_clear2");

        // Reset mid-stream.
        for (int i = 0; i < 5; i++) key(8'hA0 + 8'(i));
        rd(2'd1, 32'h0000_0005, "pre_reset_status");
        check("pre_reset_irq", 32'(irq), 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1, 32'h0001_0000, "post_reset_status");
        key(8'h2B);
        rd(2'd0, 32'h0000_802B, "post_reset_data");
        rd(2'd2, 32'h0000_0000, "post_reset_ctrl");

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
